// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmitter between NREQ byte producers with round-robin
// arbitration. One byte is captured per grant. The block then raises tx_start
// and waits for the transmitter to report busy and go idle again before it
// serves the next requester. If the transmitter never reports busy within
// TIMEOUT_CYC cycles, the byte is dropped and tx_timeout pulses.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   req        level request per requester, held with data until granted
//   req_data   byte of requester i on bits [8i+7:8i]
//   grant      one-hot one-cycle pulse: that requester's byte was captured
//   tx_data    byte to transmitter, stable from grant until next grant
//   tx_start   start level to transmitter
//   tx_busy    transmitter busy flag (baud-clock domain, resynchronised here)
//   tx_timeout one-cycle pulse when the transmitter never acknowledged start
//   busy       high whenever the arbiter is not idle
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 tx_timeout,
  output logic                 busy
);

  localparam int DATA_W = 8;
  localparam int PW     = $clog2(NREQ);
  localparam int CW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic             busy_p0;
  logic             busy_p1;

  logic             any_req;
  logic [PW-1:0]    win;
  logic [PW-1:0]    next_ptr;
  logic [PW:0]      sum;
  logic [PW-1:0]    idx;

  // Round-robin search starting at ptr. The loop runs from the farthest
  // offset down to offset 0, so the nearest asserted request is written last
  // and wins.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    sum     = '0;
    idx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      idx = sum[PW-1:0];
      if (req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  assign next_ptr = (win == PTR_LAST) ? '0 : win + PW'(1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      grant      <= '0;
      tx_timeout <= 1'b0;
      busy_p0    <= 1'b0;
      busy_p1    <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop resynchroniser for the baud-domain busy flag
      busy_p0    <= tx_busy;
      busy_p1    <= busy_p0;

      grant      <= '0;
      tx_timeout <= 1'b0;

      case (state)
        IDLE: begin
          // A stale busy_p1 here is ignored; the START state waits for busy
          // as the real acknowledgement.
          if (any_req) begin
            tx_data  <= req_data[{win, 3'b000} +: DATA_W];
            grant    <= NREQ'(1) << win;
            ptr      <= next_ptr;
            cnt      <= '0;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (busy_p1) begin
            tx_start <= 1'b0;
            state    <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            // ptr already points past the dropped requester
            tx_timeout <= 1'b1;
            tx_start   <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!busy_p1) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed sequence with a grant scoreboard
// and a simple transmitter model driving tx_busy.
module tb_uart_tx_arbiter;

  localparam int NREQ        = 4;
  localparam int TIMEOUT_CYC = 16;

  logic                clk      = 1'b0;
  logic                rst_n    = 1'b1;
  logic [NREQ-1:0]     req      = '0;
  logic [8*NREQ-1:0]   req_data = '0;
  logic [NREQ-1:0]     grant;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                tx_busy  = 1'b0;
  logic                tx_timeout;
  logic                busy;

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_timeout (tx_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int gcount      = 0;
  int last_gcyc   = -100;

  bit model_en   = 1'b0;
  int model_dly  = 5;
  int model_hold = 20;
  int rise_cyc   = 0;
  int fall_cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every grant pops the next expected requester/byte.
  always @(negedge clk) begin
    exp_t e;
    if (grant !== '0) begin
      gcount++;
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("grant_onehot", 32'(grant), 32'(1) << e.idx);
        check("grant_data", 32'(tx_data), 32'(e.data));
        check("grant_spacing", 32'((cyc - last_gcyc) >= 4), 32'd1);
      end
      last_gcyc = cyc;
    end
  end

  // Transmitter model: sees tx_start, raises busy after a delay, holds it.
  always begin
    @(negedge clk);
    if (model_en && tx_start === 1'b1) begin
      repeat (model_dly) @(negedge clk);
      tx_busy  = 1'b1;
      rise_cyc = cyc;
      repeat (model_hold) @(negedge clk);
      tx_busy  = 1'b0;
      fall_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic cond(input int sel);
    case (sel)
      0:       return tx_start === 1'b0;
      1:       return busy === 1'b0;
      2:       return tx_timeout === 1'b1;
      3:       return tx_busy === 1'b1;
      default: return grant !== '0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string tag);
    int n = 0;
    while (!cond(sel) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(cond(sel)), 32'd1);
  endtask

  task automatic wait_grants(input int target, input int budget, input string tag);
    int n = 0;
    while (gcount < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(gcount), 32'(target));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int base;
    int g1;

    // Reset with random request activity
    #2 rst_n = 1'b0;
    req_data = 32'($urandom);
    repeat (4) begin
      @(negedge clk);
      req = NREQ'($urandom);
      #1;
      check("rst_grant", 32'(grant), 32'd0);
    end
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_timeout", 32'(tx_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_rst_grant", 32'(grant), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    // Single byte from requester 0
    model_en   = 1'b1;
    model_dly  = 5;
    model_hold = 20;
    req_data   = 32'h0000_0041;
    exp_q.push_back('{0, 8'h41});
    req = 4'b0001;
    wait_grants(1, 10, "single_grant");
    req = '0;
    check("single_start_high", 32'(tx_start), 32'd1);
    check("single_busy_high", 32'(busy), 32'd1);
    wait_for(3, 20, "single_txbusy_rise");
    wait_for(0, 20, "single_start_fall");
    check("single_start_lag", 32'(cyc - rise_cyc), 32'd3);
    wait_for(1, 60, "single_busy_fall");
    check("single_busy_lag", 32'(cyc - fall_cyc), 32'd3);
    check("single_data_hold", 32'(tx_data), 32'h41);
    check("single_gcount", 32'(gcount), 32'd1);

    // All four requesting continuously
    reset_dut();
    model_dly  = 2;
    model_hold = 4;
    req_data   = 32'h1312_1110;
    exp_q.push_back('{0, 8'h10});
    exp_q.push_back('{1, 8'h11});
    exp_q.push_back('{2, 8'h12});
    exp_q.push_back('{3, 8'h13});
    exp_q.push_back('{0, 8'h10});
    base = gcount;
    req  = 4'b1111;
    wait_grants(base + 5, 200, "rr_grants");
    req = '0;
    wait_for(1, 60, "rr_idle");

    // Fairness wrap: serve 1, then 3 and 0 together
    reset_dut();
    req_data = 32'hD3C2_B1A0;
    exp_q.push_back('{1, 8'hB1});
    base = gcount;
    req  = 4'b0010;
    wait_grants(base + 1, 10, "wrap_first");
    req = '0;
    wait_for(1, 60, "wrap_idle1");
    exp_q.push_back('{3, 8'hD3});
    exp_q.push_back('{0, 8'hA0});
    req = 4'b1001;
    wait_grants(base + 2, 10, "wrap_grant3");
    req[3] = 1'b0;
    wait_grants(base + 3, 60, "wrap_grant0");
    req = '0;
    wait_for(1, 60, "wrap_idle2");

    // Timeout with a transmitter that never reports busy
    model_en = 1'b0;
    reset_dut();
    req_data = 32'hEE55_0000;
    exp_q.push_back('{2, 8'h55});
    exp_q.push_back('{2, 8'h55});
    base = gcount;
    req  = 4'b0100;
    wait_grants(base + 1, 10, "to_grant");
    g1 = last_gcyc;
    wait_for(2, 40, "to_pulse");
    check("to_lag", 32'(cyc - g1), 32'(TIMEOUT_CYC));
    check("to_start_low", 32'(tx_start), 32'd0);
    check("to_busy_low", 32'(busy), 32'd0);
    wait_grants(base + 2, 3, "to_regrant");
    req = '0;
    check("to_regrant_lag", 32'(last_gcyc - g1), 32'(TIMEOUT_CYC + 1));
    check("to_pulse_width", 32'(tx_timeout), 32'd0);
    wait_for(2, 40, "to_second_pulse");
    // ptr must now be past requester 2
    exp_q.push_back('{3, 8'hEE});
    req = 4'b1100;
    wait_grants(base + 3, 5, "to_ptr_advance");
    req = '0;
    wait_for(2, 40, "to_third_pulse");
    wait_for(1, 5, "to_idle");

    // Reset in the middle of a frame
    model_en   = 1'b1;
    model_dly  = 2;
    model_hold = 30;
    req_data   = 32'h0000_7700;
    exp_q.push_back('{1, 8'h77});
    base = gcount;
    req  = 4'b0010;
    wait_grants(base + 1, 10, "mid_grant");
    req = '0;
    wait_for(3, 20, "mid_txbusy_rise");
    wait_for(0, 20, "mid_in_wait");
    check("mid_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base  = gcount;
    repeat (5) @(negedge clk);
    #1;
    check("mid_no_grant", 32'(gcount), 32'(base));
    req_data = 32'h0000_00A5;
    exp_q.push_back('{0, 8'hA5});
    req = 4'b0001;
    wait_grants(base + 1, 10, "mid_new_grant");
    req = '0;
    wait_for(1, 100, "mid_final_idle");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between up to NREQ byte producers (keyboard echo, status/message generators, display mirror). It sits between the producers and the transmitter's data/start inputs. It accepts one byte per grant, starts the transmitter and waits for the frame to finish before serving the next requester. The transmitter runs on the baud clock, so its busy flag is resynchronised here.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT_CYC, 65536: clk cycles allowed in START for the transmitter to report busy.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  level request per requester. The requester holds it with its data stable until granted.
- req_data  input  8*NREQ  byte of requester i on bits [8i+7:8i].
- grant  output  NREQ  one-hot, one-cycle pulse; the byte of that requester was captured.
- tx_data  output  8  byte to transmitter, registered, stable from grant until next grant.
- tx_start  output  1  start level to transmitter.
- tx_busy  input  1  transmitter busy (asynchronous to clk).
- tx_timeout  output  1  one-cycle pulse when START times out.
- busy  output  1  high whenever state is not IDLE.

## Operation
- tx_busy passes through a 2-flop synchroniser; busy_s below is its output.
- Round-robin pointer ptr, width clog2(NREQ), reset 0. Search order is ptr, ptr+1, … wrapping mod NREQ; the first asserted req wins (index w). After a grant, ptr <= (w+1) mod NREQ. Timeouts also advance ptr past w.
- FSM states: IDLE, START, WAIT_DONE.
- IDLE: if any req is high: latch tx_data <= req_data[w], pulse grant[w], clear counter, go to START. Otherwise stay.
- START: tx_start = 1.
  - If busy_s = 1: go to WAIT_DONE, tx_start <= 0.
  - Else, if counter == TIMEOUT_CYC-1: pulse tx_timeout, tx_start <= 0, go to IDLE; the byte is dropped.
  - Else counter += 1.
- WAIT_DONE: tx_start = 0. When busy_s = 0, go to IDLE.
- Requests are sampled only in IDLE. A req that drops before grant is simply not served.
- A requester still asserting req after its grant is treated as a new byte. It competes normally and is not served twice in a row while others are waiting.
- busy_s high in IDLE (stale): start arbitration anyway. Correct handshake comes from the START → busy rise requirement.

## Timing
- Reset values: state IDLE, ptr 0, counter 0, tx_data 0x00, tx_start 0, grant 0, tx_timeout 0, busy 0, synchroniser flops 0. Reset acts immediately, including mid-frame. The transmitter's frame is not aborted by this block.
- Grant latency: req high at edge k in IDLE gives grant, tx_data, busy and tx_start (registered) all valid after edge k. grant is high for exactly one cycle.
- tx_start falls 1 cycle after busy_s rises; busy_s lags tx_busy by 2 clk edges.
- Return to IDLE 1 cycle after busy_s falls. The next grant comes on the following edge, so the minimum gap from busy_s low to the next grant is 2 cycles.
- Counter width is clog2(TIMEOUT_CYC). A timeout fires exactly TIMEOUT_CYC cycles after entering START.
- At most one byte is in flight. grant pulses are at least 4 cycles apart.

## Test plan
- Reset: hold rst_n low with random req. Then all outputs are 0, with no grant for 3 cycles after release unless req is high.
- Single byte: req[0]=1 with data 0x41; transmitter model raises tx_busy 5 cycles after tx_start and holds it 20 cycles. Expect grant=0001 once, tx_data=0x41, tx_start falling 3 cycles after tx_busy rises, busy falling 3 cycles after tx_busy falls.
- All four requesting continuously (data 0x10..0x13): grant order 0,1,2,3,0,1…; tx_data sequence 0x10,0x11,0x12,0x13,0x10.
- Fairness wrap: after serving requester 1 (ptr=2), raise req[3] and req[0] together. Expect grant 3, then 0.
- Timeout: TIMEOUT_CYC=16, tx_busy stuck 0, req[2]=1 with 0x55. Expect tx_timeout pulse 16 cycles after entering START, return to IDLE, then re-grant of requester 2 if still requesting.
- Reset mid-frame: drop rst_n during WAIT_DONE. Expect busy, tx_start and grant to go 0 at once, with no grant until a new request arrives after release.
